// File: rtl/dmm_line_port_if.sv
// rtl/dmm_line_port_if.sv - request and memory-line signal bundle for dmm_line_port
interface dmm_line_port_if;
  logic         req_strobe_i;
  logic [31:0]  req_addr_i;
  logic         req_rw_i;
  logic [255:0] req_data_i;
  logic [7:0]   req_size_i;
  logic         req_done_o;
  logic [255:0] req_data_o;
  logic         req_err_o;
  logic         busy_o;
  logic         mem_strobe_o;
  logic [31:0]  mem_addr_o;
  logic         mem_rw_o;
  logic [255:0] mem_data_o;
  logic         mem_done_i;
  logic [255:0] mem_data_i;

  modport slave (
    input  req_strobe_i, req_addr_i, req_rw_i, req_data_i, req_size_i,
    output req_done_o, req_data_o, req_err_o, busy_o,
    output mem_strobe_o, mem_addr_o, mem_rw_o, mem_data_o,
    input  mem_done_i, mem_data_i
  );

  modport master (
    output req_strobe_i, req_addr_i, req_rw_i, req_data_i, req_size_i,
    input  req_done_o, req_data_o, req_err_o, busy_o,
    input  mem_strobe_o, mem_addr_o, mem_rw_o, mem_data_o,
    output mem_done_i, mem_data_i
  );
endinterface

// File: rtl/dmm_line_port.sv
// rtl/dmm_line_port.sv - byte-granular request to aligned 256-bit line transaction adapter
module dmm_line_port #(
  parameter bit FULL_LINE_BYPASS = 1'b1,
  parameter int LINE_BYTES       = 32
) (
  input logic            clk,
  input logic            rst,
  dmm_line_port_if.slave bus
);
  generate
    if (LINE_BYTES != 32) begin : g_bad_cfg
      $error("dmm_line_port: LINE_BYTES must be 32");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RD_LINE, WR_LINE, DONE} state_t;
  state_t state, state_nx;

  logic [4:0]   off_q;
  logic [8:0]   end_q;
  logic [7:0]   size_q;
  logic         rw_q;
  logic         err_q;
  logic         gap_q;
  logic [31:0]  line_addr_q;
  logic [255:0] wdata_q;
  logic [255:0] line_q;
  logic [255:0] rdata_q;

  logic [4:0]   in_off;
  logic [8:0]   in_end;
  logic         in_illegal;
  logic         in_empty;
  logic         in_bypass;

  always_comb begin
    in_off     = bus.req_addr_i[4:0];
    in_end     = {4'd0, in_off} + {1'b0, bus.req_size_i};
    in_illegal = (bus.req_size_i > 8'd32) || (in_end > 9'd32);
    in_empty   = (bus.req_size_i == 8'd0);
    in_bypass  = FULL_LINE_BYPASS && bus.req_rw_i && (in_off == 5'd0) && (bus.req_size_i == 8'd32);
  end

  // Read extraction and write merge share the latched byte offset.
  logic [31:0]  keep_mask;
  logic [31:0]  wr_mask;
  logic [255:0] rd_shift;
  logic [255:0] wr_shift;
  logic [255:0] rd_extract;
  logic [255:0] merged;

  always_comb begin
    keep_mask  = '0;
    wr_mask    = '0;
    rd_extract = '0;
    merged     = '0;
    rd_shift   = bus.mem_data_i >> {off_q, 3'b000};
    wr_shift   = wdata_q << {off_q, 3'b000};
    for (int i = 0; i < 32; i++) begin
      keep_mask[i] = 9'(i) < {1'b0, size_q};
      wr_mask[i]   = (9'(i) >= {4'd0, off_q}) && (9'(i) < end_q);
      rd_extract[8*i +: 8] = keep_mask[i] ? rd_shift[8*i +: 8] : 8'h00;
      merged[8*i +: 8]     = wr_mask[i] ? wr_shift[8*i +: 8] : bus.mem_data_i[8*i +: 8];
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (bus.req_strobe_i) begin
          if (in_illegal || in_empty) state_nx = DONE;
          else if (in_bypass)         state_nx = WR_LINE;
          else                        state_nx = RD_LINE;
        end
      end
      RD_LINE: begin
        if (bus.mem_done_i) state_nx = rw_q ? WR_LINE : DONE;
      end
      WR_LINE: begin
        // gap_q marks the merge cycle; the write strobe has not been raised yet.
        if (!gap_q && bus.mem_done_i) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      off_q       <= '0;
      end_q       <= '0;
      size_q      <= '0;
      rw_q        <= 1'b0;
      err_q       <= 1'b0;
      gap_q       <= 1'b0;
      line_addr_q <= '0;
      wdata_q     <= '0;
      line_q      <= '0;
      rdata_q     <= '0;
    end else begin
      state <= state_nx;
      gap_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_strobe_i) begin
            off_q   <= in_off;
            end_q   <= in_end;
            size_q  <= bus.req_size_i;
            rw_q    <= bus.req_rw_i;
            wdata_q <= bus.req_data_i;
            err_q   <= in_illegal;
            if (!in_illegal && !in_empty)
              line_addr_q <= {bus.req_addr_i[31:5], 5'b00000};
            if (!in_illegal && in_bypass)
              line_q <= bus.req_data_i;
            if (!in_illegal && in_empty && !bus.req_rw_i)
              rdata_q <= '0;
          end
        end
        RD_LINE: begin
          if (bus.mem_done_i) begin
            if (rw_q) begin
              line_q <= merged;
              gap_q  <= 1'b1;
            end else begin
              rdata_q <= rd_extract;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_done_o   = (state == DONE);
  assign bus.req_err_o    = (state == DONE) && err_q;
  assign bus.busy_o       = (state != IDLE);
  assign bus.req_data_o   = rdata_q;
  assign bus.mem_strobe_o = (state == RD_LINE) || ((state == WR_LINE) && !gap_q);
  assign bus.mem_rw_o     = (state == WR_LINE);
  assign bus.mem_addr_o   = line_addr_q;
  assign bus.mem_data_o   = line_q;
endmodule

// File: tb/tb_dmm_line_port.sv
// tb/tb_dmm_line_port.sv - scoreboard bench for dmm_line_port, bypass and non-bypass side by side
`timescale 1ns/1ps
module tb_dmm_line_port;
  localparam int M = 3;

  typedef struct {
    logic [31:0]  addr;
    logic         rw;
    logic [255:0] data;
  } txn_t;

  typedef struct {
    logic         err;
    logic [255:0] rdata;
    int           lat;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         r_stb;
  logic [31:0]  r_addr;
  logic         r_rw;
  logic [255:0] r_data;
  logic [7:0]   r_size;

  logic         mstb[2];
  logic         mrw[2];
  logic [31:0]  maddr[2];
  logic [255:0] mwdata[2];
  logic         mdone[2];
  logic [255:0] mrdata[2];
  logic         rdone[2];
  logic         rerr[2];
  logic         rbusy[2];
  logic [255:0] rdata_o[2];

  dmm_line_port_if ifb();
  dmm_line_port_if ifn();

  dmm_line_port #(.FULL_LINE_BYPASS(1'b1), .LINE_BYTES(32)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));
  dmm_line_port #(.FULL_LINE_BYPASS(1'b0), .LINE_BYTES(32)) dut_n (.clk(clk), .rst(rst), .bus(ifn.slave));

  assign ifb.req_strobe_i = r_stb;
  assign ifb.req_addr_i   = r_addr;
  assign ifb.req_rw_i     = r_rw;
  assign ifb.req_data_i   = r_data;
  assign ifb.req_size_i   = r_size;
  assign ifn.req_strobe_i = r_stb;
  assign ifn.req_addr_i   = r_addr;
  assign ifn.req_rw_i     = r_rw;
  assign ifn.req_data_i   = r_data;
  assign ifn.req_size_i   = r_size;

  assign ifb.mem_done_i = mdone[0];
  assign ifb.mem_data_i = mrdata[0];
  assign ifn.mem_done_i = mdone[1];
  assign ifn.mem_data_i = mrdata[1];

  assign mstb[0] = ifb.mem_strobe_o;   assign mstb[1] = ifn.mem_strobe_o;
  assign mrw[0] = ifb.mem_rw_o;        assign mrw[1] = ifn.mem_rw_o;
  assign maddr[0] = ifb.mem_addr_o;    assign maddr[1] = ifn.mem_addr_o;
  assign mwdata[0] = ifb.mem_data_o;   assign mwdata[1] = ifn.mem_data_o;
  assign rdone[0] = ifb.req_done_o;    assign rdone[1] = ifn.req_done_o;
  assign rerr[0] = ifb.req_err_o;      assign rerr[1] = ifn.req_err_o;
  assign rbusy[0] = ifb.busy_o;        assign rbusy[1] = ifn.busy_o;
  assign rdata_o[0] = ifb.req_data_o;  assign rdata_o[1] = ifn.req_data_o;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int req_cyc = 0;
  int ndone[2];
  logic inject = 1'b0;
  logic [255:0] last_rd[2];
  logic [255:0] mem[2][64];
  logic [255:0] refm[64];
  txn_t txq0[$];
  txn_t txq1[$];
  rsp_t rq0[$];
  rsp_t rq1[$];

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] ref_extract(input logic [255:0] line, input int off, input int size);
    logic [255:0] r = '0;
    for (int b = 0; b < size; b++) r[8*b +: 8] = line[8*(off+b) +: 8];
    return r;
  endfunction

  function automatic logic [255:0] ref_merge(input logic [255:0] line, input logic [255:0] d, input int off, input int size);
    logic [255:0] r = line;
    for (int b = 0; b < size; b++) r[8*(off+b) +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic push_txn(input int k, input txn_t t);
    if (k == 0) txq0.push_back(t); else txq1.push_back(t);
  endtask

  task automatic push_rsp(input int k, input rsp_t r);
    if (k == 0) rq0.push_back(r); else rq1.push_back(r);
  endtask

  task automatic serve(input int k);
    txn_t e;
    int idx = int'(maddr[k][10:5]);
    if ((k == 0 && txq0.size() == 0) || (k == 1 && txq1.size() == 0)) begin
      check("txn_unexpected", maddr[k], 256'h0);
    end else begin
      if (k == 0) e = txq0.pop_front(); else e = txq1.pop_front();
      check("mem_addr", maddr[k], e.addr);
      check("mem_rw", mrw[k], e.rw);
      if (e.rw) check("mem_wdata", mwdata[k], e.data);
    end
    if (mrw[k]) mem[k][idx] = mwdata[k];
    else        mrdata[k] = mem[k][idx];
  endtask

  // Memory model: done arrives M cycles after the strobe is first seen high.
  task automatic responder(input int k);
    int cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (inject) begin
        mdone[k] = 1'b1;
        cnt = 0;
      end else if (mdone[k]) begin
        mdone[k] = 1'b0;
        cnt = 0;
        check("strobe_gap", mstb[k], 1'b0);
      end else if (rst || !mstb[k]) begin
        cnt = 0;
      end else begin
        cnt++;
        if (cnt > M) begin
          serve(k);
          mdone[k] = 1'b1;
          cnt = 0;
        end
      end
    end
  endtask

  task automatic rsp_mon(input int k);
    rsp_t r;
    forever begin
      @(posedge clk); #1;
      if (rdone[k]) begin
        ndone[k]++;
        if ((k == 0 && rq0.size() == 0) || (k == 1 && rq1.size() == 0)) begin
          check("done_unexpected", 1'b1, 1'b0);
        end else begin
          if (k == 0) r = rq0.pop_front(); else r = rq1.pop_front();
          check("req_err", rerr[k], r.err);
          check("req_data", rdata_o[k], r.rdata);
          if (r.lat >= 0) check("latency", 256'(cyc - req_cyc), 256'(r.lat));
        end
      end else if (rerr[k]) begin
        check("err_without_done", 1'b1, 1'b0);
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial responder(0);
  initial responder(1);
  initial rsp_mon(0);
  initial rsp_mon(1);

  task automatic do_req(input logic [31:0] addr, input logic rw, input logic [255:0] data, input int size, input bit stray);
    int off = int'(addr[4:0]);
    int endv = off + size;
    int idx = int'(addr[10:5]);
    bit illegal = (size > 32) || (endv > 32);
    logic [255:0] merged = ref_merge(refm[idx], data, off, size);
    logic [31:0] la = {addr[31:5], 5'b00000};
    int d0, d1;
    bit ok;
    for (int k = 0; k < 2; k++) begin
      rsp_t r;
      r.err = illegal;
      r.lat = 1;
      if (illegal) begin
        r.rdata = last_rd[k];
      end else if (size == 0) begin
        if (!rw) last_rd[k] = '0;
        r.rdata = last_rd[k];
      end else if (!rw) begin
        push_txn(k, '{la, 1'b0, '0});
        last_rd[k] = ref_extract(refm[idx], off, size);
        r.rdata = last_rd[k];
        r.lat = M + 2;
      end else begin
        bit bypass = (k == 0) && (off == 0) && (size == 32);
        if (!bypass) push_txn(k, '{la, 1'b0, '0});
        push_txn(k, '{la, 1'b1, merged});
        r.rdata = last_rd[k];
        r.lat = bypass ? M + 2 : -1;
      end
      push_rsp(k, r);
    end
    if (!illegal && size > 0 && rw) refm[idx] = merged;

    @(posedge clk); #1;
    r_addr = addr; r_rw = rw; r_data = data; r_size = 8'(size); r_stb = 1'b1;
    req_cyc = cyc;
    d0 = ndone[0]; d1 = ndone[1];
    @(posedge clk); #1;
    r_stb = 1'b0;
    if (stray) begin
      @(posedge clk); #1;
      r_addr = 32'h7000_0140; r_rw = 1'b0; r_size = 8'd4; r_stb = 1'b1;
      @(posedge clk); #1;
      r_stb = 1'b0;
    end
    for (int i = 0; i < 200 && !(ndone[0] > d0 && ndone[1] > d1); i++) @(posedge clk);
    ok = (ndone[0] > d0) && (ndone[1] > d1);
    check("done_timeout", ok, 1'b1);
    repeat (2) @(posedge clk);
    check("one_done_b", 256'(ndone[0] - d0), 256'd1);
    check("one_done_n", 256'(ndone[1] - d1), 256'd1);
  endtask

  task automatic reset_mid_write();
    int d0, d1;
    @(posedge clk); #1;
    r_addr = 32'h7000_0080; r_rw = 1'b1; r_data = {8{32'hA5A5_0F0F}}; r_size = 8'd32; r_stb = 1'b1;
    @(posedge clk); #1;
    r_stb = 1'b0;
    check("wr_phase_b", {mstb[0], mrw[0]}, 2'b11);
    d0 = ndone[0]; d1 = ndone[1];
    rst = 1'b1;
    #1;
    check("rst_strobe_b", mstb[0], 1'b0);
    check("rst_strobe_n", mstb[1], 1'b0);
    check("rst_busy_b", rbusy[0], 1'b0);
    check("rst_busy_n", rbusy[1], 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    last_rd[0] = '0; last_rd[1] = '0;
    @(negedge clk); inject = 1'b1;
    @(negedge clk); inject = 1'b0;
    repeat (4) @(posedge clk);
    check("stale_done_b", 256'(ndone[0] - d0), 256'd0);
    check("stale_done_n", 256'(ndone[1] - d1), 256'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] pat;
    r_stb = 1'b0; r_addr = '0; r_rw = 1'b0; r_data = '0; r_size = '0;
    for (int k = 0; k < 2; k++) begin
      mdone[k] = 1'b0; mrdata[k] = '0; ndone[k] = 0; last_rd[k] = '0;
    end
    for (int b = 0; b < 32; b++) pat[8*b +: 8] = 8'(b);
    for (int i = 0; i < 64; i++) begin
      refm[i] = pat; mem[0][i] = pat; mem[1][i] = pat;
    end

    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check("rst_done", rdone[k], 1'b0);
      check("rst_busy", rbusy[k], 1'b0);
      check("rst_mstb", mstb[k], 1'b0);
      check("rst_rdata", rdata_o[k], 256'h0);
      check("rst_maddr", maddr[k], 256'h0);
    end
    rst = 1'b0;

    do_req(32'h7000_0024, 1'b0, '0, 4, 1'b0);
    check("tp_read_lo", rdata_o[0][31:0], 32'h0706_0504);
    check("tp_read_hi", rdata_o[1][255:32], 224'h0);
    do_req(32'h7000_001C, 1'b1, 256'hDEAD_BEEF, 4, 1'b0);
    do_req(32'h7000_0000, 1'b0, '0, 32, 1'b0);
    check("tp_merge_hi", rdata_o[1][255:224], 32'hDEAD_BEEF);
    do_req(32'h7000_0040, 1'b1, {8{$urandom}}, 32, 1'b0);
    do_req(32'h7000_003C, 1'b0, '0, 8, 1'b0);
    do_req(32'h7000_0010, 1'b0, '0, 0, 1'b0);
    do_req(32'h7000_0010, 1'b1, 256'h1234, 0, 1'b0);
    do_req(32'h7000_0020, 1'b0, '0, 40, 1'b0);
    do_req(32'h7000_0020, 1'b1, 256'h55, 40, 1'b0);
    do_req(32'h7000_0044, 1'b0, '0, 16, 1'b1);
    do_req(32'h7000_003F, 1'b0, '0, 1, 1'b0);
    for (int n = 0; n < 12; n++) begin
      int ln = $urandom_range(0, 7);
      int of = $urandom_range(0, 31);
      int sz = $urandom_range(1, 32 - of);
      do_req(32'h7000_0000 + 32'(ln * 32 + of), 1'($urandom_range(0, 1)), {8{$urandom}}, sz, 1'b0);
    end

    reset_mid_write();
    do_req(32'h7000_0080, 1'b0, '0, 32, 1'b0);

    check("txq_b_empty", 256'(txq0.size()), 256'd0);
    check("txq_n_empty", 256'(txq1.size()), 256'd0);
    check("rq_b_empty", 256'(rq0.size()), 256'd0);
    check("rq_n_empty", 256'(rq1.size()), 256'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
